// File: rtl/banked_dual_port_memory_pkg.sv
// Shared constants and helpers for the banked dual-port memory.
package mem_pkg;

    localparam int          CNT_WIDTH = 16;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    // Encoding of the last_winner flag.
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    function automatic int bank_bits(input int num_banks);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < num_banks) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/banked_dual_port_memory_bank.sv
// Single-port, byte-enabled RAM bank with a registered (synchronous) read port.
module mem_bank #(
    parameter int ROW_WIDTH  = 10,
    parameter int DATA_WIDTH = 16,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             en,
    input  logic                             we,
    input  logic [ROW_WIDTH-1:0]             row,
    input  logic [DATA_WIDTH-1:0]            din,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
    output logic [DATA_WIDTH-1:0]            rdata
);
    import mem_pkg::*;

    localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ROW_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read data only moves on a read, so it stays stable for the top-level hold path.
    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem_q[row];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Storage is deliberately not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem_q[row][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/banked_dual_port_memory.sv
// Two-port, word-interleaved multi-bank RAM with fair same-bank arbitration.
module banked_dual_port_memory
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int BYTE_WIDTH = 8,
    parameter int NUM_BANKS  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             a_req,
    input  logic                             a_we,
    input  logic [ADDR_WIDTH-1:0]            a_addr,
    input  logic [DATA_WIDTH-1:0]            a_din,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] a_be,
    output logic                             a_gnt,
    output logic                             a_rvalid,
    output logic [DATA_WIDTH-1:0]            a_dout,
    input  logic                             b_req,
    input  logic                             b_we,
    input  logic [ADDR_WIDTH-1:0]            b_addr,
    input  logic [DATA_WIDTH-1:0]            b_din,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] b_be,
    output logic                             b_gnt,
    output logic                             b_rvalid,
    output logic [DATA_WIDTH-1:0]            b_dout,
    output logic [CNT_WIDTH-1:0]             conflict_cnt
);
    localparam int BB    = bank_bits(NUM_BANKS);
    localparam int ROW_W = ADDR_WIDTH - BB;
    localparam int LANES = DATA_WIDTH / BYTE_WIDTH;

    logic [BB-1:0]         a_bank, b_bank;
    logic [ROW_W-1:0]      a_row, b_row;
    logic                  conflict;
    logic                  last_winner_d, last_winner_q;
    logic [CNT_WIDTH-1:0]  cnt_d, cnt_q;
    logic                  a_rvalid_d, a_rvalid_q, b_rvalid_d, b_rvalid_q;
    logic [BB-1:0]         a_bank_d, a_bank_q, b_bank_d, b_bank_q;
    logic [DATA_WIDTH-1:0] a_dout_d, a_dout_q, b_dout_d, b_dout_q;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

    assign a_bank   = a_addr[BB-1:0];
    assign b_bank   = b_addr[BB-1:0];
    assign a_row    = a_addr[ADDR_WIDTH-1:BB];
    assign b_row    = b_addr[ADDR_WIDTH-1:BB];
    assign conflict = !rst && a_req && b_req && (a_bank == b_bank);

    // Arbiter: on a same-bank clash the port that did not win last time is granted.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (rst) begin
            a_gnt = 1'b0;
            b_gnt = 1'b0;
        end else if (conflict) begin
            a_gnt = (last_winner_q == PORT_B);
            b_gnt = (last_winner_q == PORT_A);
        end else begin
            a_gnt = a_req;
            b_gnt = b_req;
        end
    end

    // Next-state for arbitration history, conflict counter and read-return tracking.
    always_comb begin
        last_winner_d = last_winner_q;
        cnt_d         = cnt_q;
        if (conflict) begin
            last_winner_d = a_gnt ? PORT_A : PORT_B;
            cnt_d         = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 16'd1;
        end else begin
            last_winner_d = last_winner_q;
            cnt_d         = cnt_q;
        end
        a_rvalid_d = a_gnt && !a_we;
        b_rvalid_d = b_gnt && !b_we;
        a_bank_d   = a_rvalid_d ? a_bank : a_bank_q;
        b_bank_d   = b_rvalid_d ? b_bank : b_bank_q;
        a_dout_d   = a_rvalid_q ? bank_rdata[a_bank_q] : a_dout_q;
        b_dout_d   = b_rvalid_q ? bank_rdata[b_bank_q] : b_dout_q;
    end

    // Control state; reset leaves B as last winner so A takes the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner_q <= PORT_B;
            cnt_q         <= '0;
            a_rvalid_q    <= 1'b0;
            b_rvalid_q    <= 1'b0;
            a_bank_q      <= '0;
            b_bank_q      <= '0;
            a_dout_q      <= '0;
            b_dout_q      <= '0;
        end else begin
            last_winner_q <= last_winner_d;
            cnt_q         <= cnt_d;
            a_rvalid_q    <= a_rvalid_d;
            b_rvalid_q    <= b_rvalid_d;
            a_bank_q      <= a_bank_d;
            b_bank_q      <= b_bank_d;
            a_dout_q      <= a_dout_d;
            b_dout_q      <= b_dout_d;
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic             sel_a, sel_b, en, we;
        logic [ROW_W-1:0] row;
        logic [DATA_WIDTH-1:0] din;
        logic [LANES-1:0] be;

        // Steer whichever granted port targets this bank onto its single port.
        always_comb begin
            sel_a = a_gnt && (a_bank == BB'(g));
            sel_b = b_gnt && (b_bank == BB'(g));
            if (sel_a) begin
                en = 1'b1; we = a_we; row = a_row; din = a_din; be = a_be;
            end else if (sel_b) begin
                en = 1'b1; we = b_we; row = b_row; din = b_din; be = b_be;
            end else begin
                en = 1'b0; we = 1'b0; row = '0; din = '0; be = '0;
            end
        end

        mem_bank #(
            .ROW_WIDTH (ROW_W),
            .DATA_WIDTH(DATA_WIDTH),
            .BYTE_WIDTH(BYTE_WIDTH)
        ) u_bank (
            .clk  (clk),
            .en   (en),
            .we   (we),
            .row  (row),
            .din  (din),
            .be   (be),
            .rdata(bank_rdata[g])
        );
    end

    assign a_rvalid     = a_rvalid_q;
    assign b_rvalid     = b_rvalid_q;
    assign a_dout       = a_dout_d;
    assign b_dout       = b_dout_d;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_banked_dual_port_memory.sv
// Directed bench for banked_dual_port_memory with hand-computed expectations.
module tb_banked_dual_port_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [11:0] a_addr, b_addr;
    logic [15:0] a_din, b_din;
    logic [1:0]  a_be, b_be;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [15:0] a_dout, b_dout;
    logic [15:0] conflict_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    banked_dual_port_memory dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_be(a_be),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_dout(a_dout),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_be(b_be),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_dout(b_dout),
        .conflict_cnt(conflict_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        a_req = 1'b0; a_we = 1'b0; a_addr = 12'h000; a_din = 16'h0000; a_be = 2'b00;
        b_req = 1'b0; b_we = 1'b0; b_addr = 12'h000; b_din = 16'h0000; b_be = 2'b00;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic we, input logic [11:0] addr, input logic [15:0] din, input logic [1:0] be);
        a_req = 1'b1; a_we = we; a_addr = addr; a_din = din; a_be = be;
    endtask

    task automatic drive_b(input logic we, input logic [11:0] addr, input logic [15:0] din, input logic [1:0] be);
        b_req = 1'b1; b_we = we; b_addr = addr; b_din = din; b_be = be;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        step();
        step();
        drive_a(1'b0, 12'h000, 16'h0000, 2'b00);
        drive_b(1'b0, 12'h001, 16'h0000, 2'b00);
        #1;
        chk("a_gnt_in_reset", a_gnt, 0);
        chk("b_gnt_in_reset", b_gnt, 0);
        idle();
        step();
        rst = 1'b0;
        #1;
        chk("reset_a_rvalid", a_rvalid, 0);
        chk("reset_b_rvalid", b_rvalid, 0);
        chk("reset_a_dout", a_dout, 16'h0000);
        chk("reset_cnt", conflict_cnt, 16'h0000);

        // Write then read back 0x004
        drive_a(1'b1, 12'h004, 16'hBEEF, 2'b11);
        #1;
        chk("wr_a_gnt", a_gnt, 1);
        step();
        drive_a(1'b0, 12'h004, 16'h0000, 2'b00);
        #1;
        chk("rd_a_gnt", a_gnt, 1);
        step();
        idle();
        chk("rd_a_rvalid", a_rvalid, 1);
        chk("rd_a_dout", a_dout, 16'hBEEF);
        step();
        chk("idle_a_rvalid", a_rvalid, 0);
        chk("hold_a_dout", a_dout, 16'hBEEF);

        // Byte-enable merge
        drive_a(1'b1, 12'h010, 16'h1234, 2'b11);
        step();
        drive_a(1'b1, 12'h010, 16'hAB00, 2'b10);
        step();
        drive_a(1'b0, 12'h010, 16'h0000, 2'b00);
        step();
        idle();
        chk("be_merge_rvalid", a_rvalid, 1);
        chk("be_merge_dout", a_dout, 16'hAB34);

        // Different banks in the same cycle
        drive_a(1'b0, 12'h001, 16'h0000, 2'b00);
        drive_b(1'b1, 12'h002, 16'h5555, 2'b11);
        #1;
        chk("xbank_a_gnt", a_gnt, 1);
        chk("xbank_b_gnt", b_gnt, 1);
        step();
        chk("xbank_cnt", conflict_cnt, 16'h0000);
        chk("xbank_a_rvalid", a_rvalid, 1);
        chk("xbank_b_rvalid", b_rvalid, 0);
        drive_a(1'b1, 12'h003, 16'h7777, 2'b11);
        drive_b(1'b0, 12'h002, 16'h0000, 2'b00);
        #1;
        chk("xbank2_a_gnt", a_gnt, 1);
        chk("xbank2_b_gnt", b_gnt, 1);
        step();
        idle();
        chk("xbank2_b_rvalid", b_rvalid, 1);
        chk("xbank2_b_dout", b_dout, 16'h5555);
        chk("xbank2_a_rvalid", a_rvalid, 0);

        // Conflict stream on bank 0 after reset
        drive_a(1'b1, 12'h000, 16'h1111, 2'b11);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive_a(1'b0, 12'h000, 16'h0000, 2'b00);
        drive_b(1'b0, 12'h004, 16'h0000, 2'b00);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("conf_a_gnt", a_gnt, ((i % 2) == 0) ? 32'd1 : 32'd0);
            chk("conf_b_gnt", b_gnt, ((i % 2) == 1) ? 32'd1 : 32'd0);
            step();
            chk("conf_a_rvalid", a_rvalid, ((i % 2) == 0) ? 32'd1 : 32'd0);
            chk("conf_b_rvalid", b_rvalid, ((i % 2) == 1) ? 32'd1 : 32'd0);
            if ((i % 2) == 0) begin
                chk("conf_a_dout", a_dout, 16'h1111);
            end else begin
                chk("conf_b_dout", b_dout, 16'hBEEF);
            end
        end
        idle();
        #1;
        chk("conf_cnt", conflict_cnt, 16'd4);

        // Reset with a read in flight
        drive_a(1'b0, 12'h004, 16'h0000, 2'b00);
        #1;
        chk("flight_gnt", a_gnt, 1);
        step();
        idle();
        rst = 1'b1;
        #1;
        chk("flight_rvalid_pre", a_rvalid, 1);
        step();
        rst = 1'b0;
        #1;
        chk("flight_rvalid_post", a_rvalid, 0);
        chk("flight_a_dout", a_dout, 16'h0000);
        chk("flight_b_dout", b_dout, 16'h0000);
        chk("flight_cnt", conflict_cnt, 16'h0000);
        drive_a(1'b0, 12'h004, 16'h0000, 2'b00);
        step();
        idle();
        chk("retain_rvalid", a_rvalid, 1);
        chk("retain_dout", a_dout, 16'hBEEF);

        // Counter saturation
        drive_a(1'b0, 12'h000, 16'h0000, 2'b00);
        drive_b(1'b0, 12'h004, 16'h0000, 2'b00);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", conflict_cnt, 16'hFFFE);
        repeat (4466) @(posedge clk);
        #1;
        chk("sat_ffff", conflict_cnt, 16'hFFFF);
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/banked_dual_port_memory.md
# banked_dual_port_memory

Two-port, multi-bank synchronous RAM. It is the parametrised successor to the team's single-port memory. Each port issues independent read/write requests against a word-interleaved bank array. Same-bank collisions are resolved by a fair arbiter, writes support byte enables, and reads return with a registered valid flag. It sits between two masters (e.g. core and DMA) and shared on-chip storage.

## Interface
- ADDR_WIDTH, 12, word address width; total depth 2**ADDR_WIDTH words
- DATA_WIDTH, 16, word width; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, bits per byte-enable lane
- NUM_BANKS, 4, bank count; power of two, 2..2**(ADDR_WIDTH-1)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- a_req / b_req  in  1  port request
- a_we / b_we  in  1  1 = write, 0 = read
- a_addr / b_addr  in  ADDR_WIDTH  word address
- a_din / b_din  in  DATA_WIDTH  write data
- a_be / b_be  in  DATA_WIDTH/BYTE_WIDTH  byte enables (writes only)
- a_gnt / b_gnt  out  1  request accepted this cycle (combinational)
- a_rvalid / b_rvalid  out  1  read data valid
- a_dout / b_dout  out  DATA_WIDTH  read data
- conflict_cnt  out  16  saturating count of bank conflicts

## Operation
- Bank select is addr[log2(NUM_BANKS)-1:0]. Row within the bank is the remaining upper bits.
- Transfer occurs when req & gnt in the same cycle. A requester with gnt=0 holds req, we, addr, din and be stable until granted.
- Different banks: both ports are granted.
- Same bank, both requesting: exactly one is granted, chosen by the last_winner flag.
  - Grant goes to the port that is not last_winner.
  - last_winner updates to the granted port.
  - conflict_cnt increments, saturating at 0xFFFF.
- A conflict is bank equality, regardless of read/write mix or exact address.
- No conflict: last_winner is unchanged.
- Write: for each lane i with be[i]=1, byte i of mem[addr] is set to din byte i. Lanes with be=0 are preserved. be=0 with we=1 is a legal no-op write and is still granted.
- Read: a granted read produces dout = mem[addr] and rvalid=1 exactly one cycle later.
  - rvalid is 0 in every cycle after a non-read or non-granted cycle.
  - dout holds its last read value while rvalid=0.
- Only one access per bank per cycle, so no intra-bank read-during-write case exists.
- Same-cycle cross-bank effect: a write on one port and a read on the other to different banks are independent.
- Reset (any cycle, including with a read in flight):
  - next-cycle a_rvalid=b_rvalid=0, a_dout=b_dout=0
  - last_winner=B, so A wins the first conflict
  - conflict_cnt=0
  - the in-flight read is discarded
  - memory contents are NOT cleared
  - gnt is forced 0 while rst=1

## Timing
- Grant: combinational from req, addr and last_winner; zero latency.
- Write: memory updated at the accepting edge; visible to a read granted the following cycle.
- Read latency: 1 cycle, request edge to rvalid/dout.
- Throughput: one access per port per cycle when banks differ. On continuous same-bank contention, each port gets every other cycle.
- Reset values: gnt 0, rvalid 0, dout 0, conflict_cnt 0.

## Structure
- Shared package mem_pkg holds:
  - function bank_bits(NUM_BANKS) = clog2
  - PORT_A/PORT_B encoding for last_winner
  - CNT_WIDTH=16 and CNT_MAX
- One sub-module, mem_bank:
  - single-port, byte-enabled, synchronous-read RAM of depth 2**ADDR_WIDTH/NUM_BANKS
  - instantiated NUM_BANKS times via generate
- Top level holds:
  - the arbiter
  - per-port bank-select registers (steer returning data to the right port)
  - rvalid registers
  - the counter

## Test plan
- Reset, write A addr 0x004 din 0xBEEF be 2'b11; next cycle read A 0x004 -> a_gnt=1, one cycle later a_rvalid=1, a_dout=0xBEEF.
- Write 0x1234 to 0x010, then write 0xAB00 with be 2'b10 -> read returns 0xAB34.
- Same cycle: A reads 0x001, B writes 0x002 (banks 1, 2) -> both gnt=1, conflict_cnt stays 0.
- Conflict stream, both ports hold reads to bank 0 (0x000, 0x004) for 4 cycles after reset:
  - grant order A, B, A, B
  - conflict_cnt=4
  - each port sees rvalid on alternate cycles
- Assert rst the cycle after a granted read of 0x004 -> next cycle rvalid=0, dout=0. A later read of 0x004 still returns 0xBEEF (contents retained).
- Force 70000 conflicts -> conflict_cnt saturates at 0xFFFF and does not wrap.
